// File: rtl/exec_trace_buffer.sv
// Captures retired-instruction records from the core into a FWFT FIFO under trigger/length control.
// Latency: a record accepted at a rising edge is visible on out_* right after that edge.
// Backpressure: out_ready stalls draining; a push into a full FIFO without a same-cycle pop is dropped and counted.
module exec_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   instr_in,
  input  logic [31:0]   alu_in,
  input  logic [3:0]    flags_in,
  input  logic [2:0]    ctrl_in,
  input  logic          arm,
  input  logic          stop,
  input  logic          trig_en,
  input  logic [31:0]   trig_pc,
  input  logic [15:0]   cap_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_alu,
  output logic [6:0]    out_flags,
  output logic [1:0]    state_out,
  output logic [AW:0]   fill,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [15:0]   cap_cnt, cap_cnt_nxt;
  logic          push_req;
  logic          push_ok;
  logic          push_drop;
  logic          pop;
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_alu   [DEPTH];
  logic [6:0]    mem_flags [DEPTH];

  // Next-state and capture decision; arm overrides stop and restarts the session.
  always_comb begin
    state_nxt   = state;
    cap_cnt_nxt = cap_cnt;
    push_req    = 1'b0;
    if (arm) begin
      state_nxt   = ST_ARMED;
      cap_cnt_nxt = 16'd0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (stop) begin
            state_nxt = ST_DONE;
          end else if (in_valid && (!trig_en || pc_in == trig_pc)) begin
            // The triggering cycle is captured as the first record.
            push_req    = 1'b1;
            cap_cnt_nxt = 16'd1;
            state_nxt   = (cap_len == 16'd1) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (stop) begin
            state_nxt = ST_DONE;
          end else if (in_valid) begin
            push_req    = 1'b1;
            cap_cnt_nxt = cap_cnt + 16'd1;
            if (cap_len != 16'd0 && cap_cnt_nxt == cap_len) begin
              state_nxt = ST_DONE;
            end
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop       = out_valid && out_ready;
    push_ok   = push_req && !reset && (fill != FULL_CNT || pop);
    push_drop = push_req && !push_ok;
  end

  // Control state, pointers, occupancy and drop accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cap_cnt  <= 16'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      cap_cnt <= cap_cnt_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (arm) begin
        overflow <= 1'b0;
        drop_cnt <= 16'd0;
      end else if (push_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Record storage; contents are not cleared, occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_pc[wr_ptr]    <= pc_in;
      mem_instr[wr_ptr] <= instr_in;
      mem_alu[wr_ptr]   <= alu_in;
      mem_flags[wr_ptr] <= {flags_in, ctrl_in};
    end
  end

  // Head record falls through combinationally from storage.
  always_comb begin
    out_valid = (fill != '0);
    out_pc    = mem_pc[rd_ptr];
    out_instr = mem_instr[rd_ptr];
    out_alu   = mem_alu[rd_ptr];
    out_flags = mem_flags[rd_ptr];
    state_out = state;
  end

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed bench for exec_trace_buffer: trigger, length, overflow, stop/arm and reset scenarios.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: out_ready toggled explicitly to fill, overflow and drain the FIFO.
module tb_exec_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc_in, instr_in, alu_in;
  logic [3:0]  flags_in;
  logic [2:0]  ctrl_in;
  logic        arm, stop, trig_en;
  logic [31:0] trig_pc;
  logic [15:0] cap_len;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, out_alu;
  logic [6:0]  out_flags;
  logic [1:0]  state_out;
  logic [4:0]  fill;
  logic        overflow;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  exec_trace_buffer #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .pc_in(pc_in), .instr_in(instr_in), .alu_in(alu_in),
    .flags_in(flags_in), .ctrl_in(ctrl_in),
    .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc), .cap_len(cap_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_alu(out_alu), .out_flags(out_flags),
    .state_out(state_out), .fill(fill), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Record fields are derived from the PC so every field is predictable.
  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    pc_in    = pc;
    instr_in = pc ^ 32'hE3A0_0000;
    alu_in   = pc + 32'h1000;
    flags_in = pc[5:2];
    ctrl_in  = pc[4:2];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    arm  = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_pc = 32'h0;
    cap_len = 16'd0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Free run, cap_len=3.
    cap_len = 16'd3; arm = 1'b1; tick();
    check("t1_armed", 32'(state_out), 32'd1);
    drive(1'b1, 32'h0); tick();
    check("t1_cap", 32'(state_out), 32'd2);
    check("t1_fill1", 32'(fill), 32'd1);
    drive(1'b1, 32'h4); tick();
    drive(1'b1, 32'h8); tick();
    check("t1_done", 32'(state_out), 32'd3);
    drive(1'b1, 32'hC); tick();
    check("t1_done_hold", 32'(state_out), 32'd3);
    check("t1_fill3", 32'(fill), 32'd3);
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    check("t1_pc0", out_pc, 32'h0);
    check("t1_instr0", out_instr, 32'hE3A0_0000);
    tick();
    check("t1_pc4", out_pc, 32'h4);
    check("t1_alu4", out_alu, 32'h1004);
    check("t1_flags4", 32'(out_flags), 32'h09);
    tick();
    check("t1_pc8", out_pc, 32'h8);
    check("t1_flags8", 32'(out_flags), 32'h12);
    tick();
    check("t1_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Trigger on PC 0x10, cap_len=2.
    trig_en = 1'b1; trig_pc = 32'h10; cap_len = 16'd2; arm = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i)); tick();
      check("t2_armed_hold", 32'(state_out), 32'd1);
    end
    drive(1'b1, 32'h10); tick();
    check("t2_trig", 32'(state_out), 32'd2);
    check("t2_fill1", 32'(fill), 32'd1);
    drive(1'b1, 32'h14); tick();
    check("t2_done", 32'(state_out), 32'd3);
    drive(1'b1, 32'h18); tick();
    check("t2_fill2", 32'(fill), 32'd2);
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    check("t2_pc10", out_pc, 32'h10);
    tick();
    check("t2_pc14", out_pc, 32'h14);
    tick();
    check("t2_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Overflow: 20 records into a 16-deep FIFO with no draining.
    trig_en = 1'b0; cap_len = 16'd20; arm = 1'b1; tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i)); tick();
    end
    drive(1'b0, 32'h0);
    check("t3_done", 32'(state_out), 32'd3);
    check("t3_fill", 32'(fill), 32'd16);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_drop", 32'(drop_cnt), 32'd4);
    check("t3_head", out_pc, 32'h100);

    // Full FIFO: push with simultaneous pop is accepted; without pop it drops.
    cap_len = 16'd0; arm = 1'b1; tick();
    check("t4_arm_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h200); tick();
    out_ready = 1'b0;
    check("t4_fill_full", 32'(fill), 32'd16);
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    check("t4_drop_clr", 32'(drop_cnt), 32'd0);
    check("t4_head", out_pc, 32'h104);
    drive(1'b1, 32'h204); tick();
    check("t4_drop1", 32'(drop_cnt), 32'd1);
    check("t4_ovf1", 32'(overflow), 32'd1);
    drive(1'b1, 32'h208); stop = 1'b1; tick();
    drive(1'b0, 32'h0);
    check("t4_stop", 32'(state_out), 32'd3);
    check("t4_stop_nocap", 32'(drop_cnt), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_pc = (i == 15) ? 32'h200 : 32'h104 + 32'(4 * i);
      check("t4_drain", out_pc, exp_pc);
      tick();
    end
    check("t4_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Unlimited capture, stop, ignored stop, re-arm keeps FIFO.
    arm = 1'b1; tick();
    check("t5_arm_ovf", 32'(overflow), 32'd0);
    check("t5_arm_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i)); tick();
    end
    drive(1'b1, 32'h314); stop = 1'b1; tick();
    check("t5_done", 32'(state_out), 32'd3);
    check("t5_fill5", 32'(fill), 32'd5);
    stop = 1'b1; tick();
    check("t5_stop_ignored", 32'(state_out), 32'd3);
    arm = 1'b1; stop = 1'b1; drive(1'b0, 32'h0); tick();
    check("t5_rearm", 32'(state_out), 32'd1);
    check("t5_fill_kept", 32'(fill), 32'd5);
    check("t5_head", out_pc, 32'h300);

    // Reset mid-capture with 7 records stored.
    drive(1'b1, 32'h400); tick();
    drive(1'b1, 32'h404); tick();
    check("t6_cap", 32'(state_out), 32'd2);
    check("t6_fill7", 32'(fill), 32'd7);
    reset = 1'b1; arm = 1'b1; out_ready = 1'b1; drive(1'b1, 32'h408); tick();
    check("t6_state", 32'(state_out), 32'd0);
    check("t6_fill", 32'(fill), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    reset = 1'b0; out_ready = 1'b0; drive(1'b0, 32'h0); tick();
    check("t6_idle_hold", 32'(state_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
